// File: rtl/uart_receiver_controller_pkg.sv
// rtl/uart_receiver_controller_pkg.sv - system controller shared constants, states and operand addresses
package uart_receiver_controller_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'hAA;
    localparam logic [7:0] CMD_READ    = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Operand registers are shared with the register file and the ALU.
    localparam int OPERAND_A_ADDRESS = 0;
    localparam int OPERAND_B_ADDRESS = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ADDR  = 3'd1,
        WR_DATA  = 3'd2,
        RD_ADDR  = 3'd3,
        OP_A     = 3'd4,
        OP_B     = 3'd5,
        ALU_FUNC = 3'd6
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_controller_if.sv
// rtl/uart_receiver_controller_if.sv - received-byte stream in, register file / ALU control out
interface uart_receiver_controller_if #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int ALU_FUNCTION_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]         received_data;
    logic                          received_data_valid;
    logic                          frame_error;
    logic                          parity_error;
    logic                          enable;
    logic [ADDRESS_WIDTH-1:0]      address;
    logic                          write_enable;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          read_enable;
    logic                          ALU_enable;
    logic [ALU_FUNCTION_WIDTH-1:0] ALU_function;
    logic                          clock_gate_enable;

    modport master (
        input  received_data, received_data_valid, frame_error, parity_error, enable,
        output address, write_enable, write_data, read_enable, ALU_enable, ALU_function,
               clock_gate_enable
    );

    modport slave (
        output received_data, received_data_valid, frame_error, parity_error, enable,
        input  address, write_enable, write_data, read_enable, ALU_enable, ALU_function,
               clock_gate_enable
    );
endinterface

// File: rtl/uart_receiver_controller.sv
// rtl/uart_receiver_controller.sv - frame parser driving register file strobes and ALU start
module uart_receiver_controller
    import uart_receiver_controller_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int ALU_FUNCTION_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_receiver_controller_if.master bus
);

    rx_state_t                     state, state_next;
    logic [ADDRESS_WIDTH-1:0]      address_next;
    logic [DATA_WIDTH-1:0]         write_data_next;
    logic [ALU_FUNCTION_WIDTH-1:0] alu_function_next;
    logic                          write_enable_next;
    logic                          read_enable_next;
    logic                          alu_enable_next;
    logic                          clock_gate_next;
    logic                          good_byte;
    logic [DATA_WIDTH-1:0]         rx_byte;

    assign rx_byte   = bus.received_data;
    assign good_byte = bus.received_data_valid && !bus.frame_error && !bus.parity_error;

    always_comb begin
        state_next        = state;
        address_next      = bus.address;
        write_data_next   = bus.write_data;
        alu_function_next = bus.ALU_function;
        write_enable_next = 1'b0;
        read_enable_next  = 1'b0;
        alu_enable_next   = 1'b0;

        if (bus.received_data_valid && !good_byte) begin
            state_next = IDLE;
        end else if (good_byte) begin
            case (state)
                IDLE: begin
                    // enable only gates the start of a command, never its operands
                    if (bus.enable) begin
                        if (rx_byte == DATA_WIDTH'(CMD_WRITE))        state_next = WR_ADDR;
                        else if (rx_byte == DATA_WIDTH'(CMD_READ))    state_next = RD_ADDR;
                        else if (rx_byte == DATA_WIDTH'(CMD_ALU_OP))  state_next = OP_A;
                        else if (rx_byte == DATA_WIDTH'(CMD_ALU_NOP)) state_next = ALU_FUNC;
                    end
                end
                WR_ADDR: begin
                    address_next = rx_byte[ADDRESS_WIDTH-1:0];
                    state_next   = WR_DATA;
                end
                WR_DATA: begin
                    write_enable_next = 1'b1;
                    write_data_next   = rx_byte;
                    state_next        = IDLE;
                end
                RD_ADDR: begin
                    read_enable_next = 1'b1;
                    address_next     = rx_byte[ADDRESS_WIDTH-1:0];
                    state_next       = IDLE;
                end
                OP_A: begin
                    write_enable_next = 1'b1;
                    address_next      = ADDRESS_WIDTH'(OPERAND_A_ADDRESS);
                    write_data_next   = rx_byte;
                    state_next        = OP_B;
                end
                OP_B: begin
                    write_enable_next = 1'b1;
                    address_next      = ADDRESS_WIDTH'(OPERAND_B_ADDRESS);
                    write_data_next   = rx_byte;
                    state_next        = ALU_FUNC;
                end
                ALU_FUNC: begin
                    alu_enable_next   = 1'b1;
                    alu_function_next = rx_byte[ALU_FUNCTION_WIDTH-1:0];
                    state_next        = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end

        // Gated clock runs while an ALU command is in flight, through its start cycle.
        clock_gate_next = (state_next == OP_A) || (state_next == OP_B) ||
                          (state_next == ALU_FUNC) || alu_enable_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            bus.address           <= '0;
            bus.write_enable      <= 1'b0;
            bus.write_data        <= '0;
            bus.read_enable       <= 1'b0;
            bus.ALU_enable        <= 1'b0;
            bus.ALU_function      <= '0;
            bus.clock_gate_enable <= 1'b0;
        end else begin
            state                 <= state_next;
            bus.address           <= address_next;
            bus.write_enable      <= write_enable_next;
            bus.write_data        <= write_data_next;
            bus.read_enable       <= read_enable_next;
            bus.ALU_enable        <= alu_enable_next;
            bus.ALU_function      <= alu_function_next;
            bus.clock_gate_enable <= clock_gate_next;
        end
    end

endmodule

// File: tb/tb_uart_receiver_controller.sv
// tb/tb_uart_receiver_controller.sv - directed and randomized byte streams against a command-queue model
module tb_uart_receiver_controller;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    uart_receiver_controller_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALU_FUNCTION_WIDTH(4)) bus ();

    uart_receiver_controller #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALU_FUNCTION_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] cmd[$];
    logic [3:0] exp_addr;
    logic [7:0] exp_wd;
    logic [3:0] exp_fn;
    logic       exp_we, exp_re, exp_ae, exp_cge;

    task automatic model_clear_all();
        cmd.delete();
        exp_addr = '0; exp_wd = '0; exp_fn = '0;
        exp_we = 0; exp_re = 0; exp_ae = 0; exp_cge = 0;
    endtask

    // A command is the list of good bytes collected so far; its opcode fixes what each later byte means.
    task automatic model_byte(input logic [7:0] b, input logic err, input logic en);
        int n;
        if (err) begin
            cmd.delete();
        end else if (cmd.size() == 0) begin
            if (en && (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD)) cmd.push_back(b);
        end else begin
            cmd.push_back(b);
            n = cmd.size() - 1;
            case (cmd[0])
                8'hAA: if (n == 1) exp_addr = b[3:0];
                       else begin exp_we = 1; exp_wd = b; cmd.delete(); end
                8'hBB: begin exp_re = 1; exp_addr = b[3:0]; cmd.delete(); end
                8'hCC: if (n < 3) begin exp_we = 1; exp_addr = 4'(n - 1); exp_wd = b; end
                       else begin exp_ae = 1; exp_fn = b[3:0]; cmd.delete(); end
                default: begin exp_ae = 1; exp_fn = b[3:0]; cmd.delete(); end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        check("write_enable", 8'(bus.write_enable), 8'(exp_we));
        check("read_enable", 8'(bus.read_enable), 8'(exp_re));
        check("ALU_enable", 8'(bus.ALU_enable), 8'(exp_ae));
        check("clock_gate_enable", 8'(bus.clock_gate_enable), 8'(exp_cge));
        check("address", 8'(bus.address), 8'(exp_addr));
        check("write_data", bus.write_data, exp_wd);
        check("ALU_function", 8'(bus.ALU_function), 8'(exp_fn));
    endtask

    task automatic cycle(input logic v, input logic [7:0] b, input logic fe, input logic pe,
                         input logic en, input logic rst);
        @(negedge clk);
        reset                   = rst;
        bus.received_data_valid = v;
        bus.received_data       = b;
        bus.frame_error         = fe;
        bus.parity_error        = pe;
        bus.enable              = en;
        exp_we = 0; exp_re = 0; exp_ae = 0;
        if (rst) model_clear_all();
        else if (v) model_byte(b, fe | pe, en);
        exp_cge = exp_ae || (cmd.size() > 0 && (cmd[0] == 8'hCC || cmd[0] == 8'hDD));
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] b, input logic fe, input logic pe, input logic en, input int gap);
        cycle(1, b, fe, pe, en, 0);
        for (int g = 0; g < gap; g++) cycle(0, 8'h00, 0, 0, en, 0);
    endtask

    initial begin
        logic [7:0] codes[4];
        codes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        reset = 1'b1;
        bus.received_data = '0; bus.received_data_valid = 0;
        bus.frame_error = 0; bus.parity_error = 0; bus.enable = 1;
        model_clear_all();
        cycle(0, 8'h00, 0, 0, 1, 1);
        cycle(0, 8'h00, 0, 0, 1, 1);

        send(8'hAA, 0, 0, 1, 2); send(8'h05, 0, 0, 1, 2); send(8'h3C, 0, 0, 1, 2);
        send(8'hBB, 0, 0, 1, 2); send(8'h05, 0, 0, 1, 2);
        send(8'hCC, 0, 0, 1, 2); send(8'h0A, 0, 0, 1, 2); send(8'h03, 0, 0, 1, 2); send(8'h01, 0, 0, 1, 2);
        send(8'hDD, 0, 0, 1, 2); send(8'h02, 0, 0, 1, 2);
        send(8'hAA, 0, 0, 1, 2); send(8'h05, 0, 0, 1, 2); send(8'h3C, 0, 1, 1, 2);
        send(8'hBB, 0, 0, 1, 2); send(8'h06, 0, 0, 1, 2);
        send(8'h55, 0, 0, 1, 2);
        send(8'hAA, 0, 0, 0, 2); send(8'h05, 0, 0, 1, 2);
        send(8'hCC, 0, 0, 1, 2); send(8'h0A, 0, 0, 1, 2);
        cycle(0, 8'h00, 0, 0, 1, 1);
        send(8'h03, 0, 0, 1, 2); send(8'h01, 0, 0, 1, 2);
        send(8'hDD, 0, 0, 1, 1);
        cycle(1, 8'h07, 0, 0, 1, 1);
        send(8'h07, 0, 0, 1, 2);
        send(8'hDD, 0, 0, 1, 1); send(8'h09, 1, 0, 1, 2);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 9);
            b = (r < 4) ? codes[r] : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) cycle(0, 8'h00, 0, 0, 1, 1);
            send(b, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 4) != 0, $urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
